sram_1rw1r_param: RTL and testbench

Parametrised, single-clock successor to the team's 1RW1R OpenRAM behavioural SRAM model, used for audio delay-line and effect buffers.
- Port 0 is read/write with per-lane write mask; port 1 is read-only.
- Adds a configurable read latency, output valid strobes and a defined read-during-write policy with a collision flag.
- Adds a hardware clear sequencer that zeroes the array so delay lines never replay stale samples.

---
 rtl/sram_1rw1r_param_pkg.sv | 27 ++
 rtl/sram_1rw1r_param_if.sv | 38 +++
 rtl/sram_clear_seq.sv | 56 +++++
 rtl/sram_1rw1r_param.sv | 120 ++++++++++++
 tb/tb_sram_1rw1r_param.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_1rw1r_param_pkg.sv
// sram_pkg: shared types and helpers for the 1RW1R SRAM.
//   sram_state_e    - clear sequencer state encoding
//   RDW_*           - port-1 read-during-write policy selectors
//   num_wmasks()    - lane count for a given word/lane width
//   cfg_ok()        - parameter legality, evaluated at elaboration
package sram_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } sram_state_e;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  function automatic int num_wmasks(input int data_width, input int wmask_width);
    return data_width / wmask_width;
  endfunction

  function automatic bit cfg_ok(input int data_width, input int wmask_width,
                                input int read_latency, input int rdw_mode);
    return (wmask_width > 0) && (data_width % wmask_width == 0) &&
           (read_latency == 1 || read_latency == 2) &&
           (rdw_mode == RDW_READ_FIRST || rdw_mode == RDW_WRITE_FIRST);
  endfunction

endpackage

// File: rtl/sram_1rw1r_param_if.sv
// sram_1rw1r_param_if: request/response bundle of the 1RW1R SRAM.
//   Port 0 (RW): csb0, web0, wmask0, addr0, din0 -> dout0, dout0_valid
//   Port 1 (R) : csb1, addr1                     -> dout1, dout1_valid, collision
//   Clear      : clr_req                          -> busy
//   master = requester side, slave = memory side.
interface sram_1rw1r_param_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int WMASK_WIDTH = 8
);
  localparam int NUM_WMASKS = sram_pkg::num_wmasks(DATA_WIDTH, WMASK_WIDTH);

  logic                  csb0;
  logic                  web0;
  logic [NUM_WMASKS-1:0] wmask0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] din0;
  logic [DATA_WIDTH-1:0] dout0;
  logic                  dout0_valid;
  logic                  csb1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] dout1;
  logic                  dout1_valid;
  logic                  collision;
  logic                  clr_req;
  logic                  busy;

  modport master (
    output csb0, web0, wmask0, addr0, din0, csb1, addr1, clr_req,
    input  dout0, dout0_valid, dout1, dout1_valid, collision, busy
  );

  modport slave (
    input  csb0, web0, wmask0, addr0, din0, csb1, addr1, clr_req,
    output dout0, dout0_valid, dout1, dout1_valid, collision, busy
  );

endinterface

// File: rtl/sram_clear_seq.sv
// sram_clear_seq: array clear sequencer.
//   clk_i, rst_i    - clock, async active-high reset
//   clr_req_i       - start a clear (honoured only when idle)
//   busy_o          - high while the sweep runs
//   clr_we_o        - zero-write strobe for the array
//   clr_addr_o      - address being zeroed this cycle
// The sweep covers every address once, 0 upward, one per cycle.
module sram_clear_seq
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_req_i,
  output logic                  busy_o,
  output logic                  clr_we_o,
  output logic [ADDR_WIDTH-1:0] clr_addr_o
);

  sram_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_we_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr_req_i) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        clr_we_o = 1'b1;
        // Natural wrap of the counter leaves it at 0 for the next sweep.
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_o     = (state_q == ST_CLEAR);
  assign clr_addr_o = cnt_q;

endmodule

// File: rtl/sram_1rw1r_param.sv
// sram_1rw1r_param: single-clock 1RW1R SRAM for audio delay lines.
//   wb_clk_i, wb_rst_i - clock, async active-high reset
//   bus (slave)        - port 0 RW with lane mask, port 1 read-only,
//                        clear request/busy (see sram_1rw1r_param_if)
// Reads return after READ_LATENCY cycles with a one-cycle valid strobe;
// outputs hold between reads. A port-1 read of the address port 0 is
// writing (with any lane enabled) flags collision and returns old or
// merged data according to RDW_MODE. While clearing, new requests are
// dropped but reads already in flight still complete.
module sram_1rw1r_param
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int WMASK_WIDTH    = 8,
  parameter int READ_LATENCY   = 1,
  parameter int RDW_MODE       = RDW_READ_FIRST,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic               wb_clk_i,
  input logic               wb_rst_i,
  sram_1rw1r_param_if.slave bus
);

  localparam int RAM_DEPTH  = 2 ** ADDR_WIDTH;
  localparam int NUM_WMASKS = num_wmasks(DATA_WIDTH, WMASK_WIDTH);

  if (!cfg_ok(DATA_WIDTH, WMASK_WIDTH, READ_LATENCY, RDW_MODE)) begin : g_cfg_err
    $error("sram_1rw1r_param: illegal DATA_WIDTH/WMASK_WIDTH/READ_LATENCY/RDW_MODE");
  end

  // ---------------------------------------------------------------- clear
  logic                  busy;
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;

  sram_clear_seq #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_seq (
    .clk_i      (wb_clk_i),
    .rst_i      (wb_rst_i),
    .clr_req_i  (bus.clr_req),
    .busy_o     (busy),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  assign bus.busy = busy;

  // -------------------------------------------------------- request decode
  logic req_en;
  logic wr0, rd0, rd1, col;

  // Reset is folded in so a non-clearing configuration cannot take
  // writes while held in reset.
  assign req_en = !busy && !wb_rst_i;
  assign wr0    = req_en && !bus.csb0 && !bus.web0 && (|bus.wmask0);
  assign rd0    = req_en && !bus.csb0 &&  bus.web0;
  assign rd1    = req_en && !bus.csb1;
  assign col    = wr0 && rd1 && (bus.addr0 == bus.addr1);

  // ---------------------------------------------------------------- array
  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
  logic [DATA_WIDTH-1:0] old0_word, old1_word, wr_word, p1_word;

  assign old0_word = mem[bus.addr0];
  assign old1_word = mem[bus.addr1];

  for (genvar i = 0; i < NUM_WMASKS; i++) begin : g_lane
    assign wr_word[i*WMASK_WIDTH +: WMASK_WIDTH] =
      bus.wmask0[i] ? bus.din0[i*WMASK_WIDTH +: WMASK_WIDTH]
                    : old0_word[i*WMASK_WIDTH +: WMASK_WIDTH];
  end

  // On a collision addr0 == addr1, so wr_word is the merged port-1 word.
  assign p1_word = (col && RDW_MODE == RDW_WRITE_FIRST) ? wr_word : old1_word;

  always_ff @(posedge wb_clk_i) begin
    if (clr_we)   mem[clr_addr]  <= '0;
    else if (wr0) mem[bus.addr0] <= wr_word;
  end

  // ------------------------------------------------------- read pipelines
  // Stage 1 captures the array word; later stages only forward it, and
  // each data stage loads only when its valid arrives so the final stage
  // (the output) holds its value between reads.
  logic [READ_LATENCY:1]                 vld0_pipe_q, vld1_pipe_q, col_pipe_q;
  logic [READ_LATENCY:1][DATA_WIDTH-1:0] d0_pipe_q, d1_pipe_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      vld0_pipe_q <= '0;
      vld1_pipe_q <= '0;
      col_pipe_q  <= '0;
      d0_pipe_q   <= '0;
      d1_pipe_q   <= '0;
    end else begin
      vld0_pipe_q[1] <= rd0;
      vld1_pipe_q[1] <= rd1;
      col_pipe_q[1]  <= col;
      if (rd0) d0_pipe_q[1] <= old0_word;
      if (rd1) d1_pipe_q[1] <= p1_word;
      for (int k = 2; k <= READ_LATENCY; k++) begin
        vld0_pipe_q[k] <= vld0_pipe_q[k-1];
        vld1_pipe_q[k] <= vld1_pipe_q[k-1];
        col_pipe_q[k]  <= col_pipe_q[k-1];
        if (vld0_pipe_q[k-1]) d0_pipe_q[k] <= d0_pipe_q[k-1];
        if (vld1_pipe_q[k-1]) d1_pipe_q[k] <= d1_pipe_q[k-1];
      end
    end
  end

  assign bus.dout0       = d0_pipe_q[READ_LATENCY];
  assign bus.dout0_valid = vld0_pipe_q[READ_LATENCY];
  assign bus.dout1       = d1_pipe_q[READ_LATENCY];
  assign bus.dout1_valid = vld1_pipe_q[READ_LATENCY];
  assign bus.collision   = col_pipe_q[READ_LATENCY];

endmodule

// File: tb/tb_sram_1rw1r_param.sv
// Bench for sram_1rw1r_param. Two instances share one stimulus stream:
// A = (READ_LATENCY 1, read-first), B = (READ_LATENCY 2, write-first).
// A word-array model schedules each read result for the cycle it is due;
// a negedge process compares both DUTs to it every cycle, and the
// directed sequences pin a few literal values.
module tb_sram_1rw1r_param;
  localparam int DW = 32, AW = 8, WW = 8, NW = 4, DEPTH = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          csb0, web0, csb1, clr_req;
  logic [NW-1:0] wmask0;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] din0;

  sram_1rw1r_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(WW)) ifa ();
  sram_1rw1r_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(WW)) ifb ();

  assign ifa.csb0 = csb0;  assign ifa.web0 = web0;  assign ifa.wmask0 = wmask0;
  assign ifa.addr0 = addr0; assign ifa.din0 = din0; assign ifa.csb1 = csb1;
  assign ifa.addr1 = addr1; assign ifa.clr_req = clr_req;
  assign ifb.csb0 = csb0;  assign ifb.web0 = web0;  assign ifb.wmask0 = wmask0;
  assign ifb.addr0 = addr0; assign ifb.din0 = din0; assign ifb.csb1 = csb1;
  assign ifb.addr1 = addr1; assign ifb.clr_req = clr_req;

  sram_1rw1r_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(WW),
    .READ_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(1))
    dut_a (.wb_clk_i(clk), .wb_rst_i(rst), .bus(ifa.slave));

  sram_1rw1r_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(WW),
    .READ_LATENCY(2), .RDW_MODE(1), .CLEAR_ON_RESET(1))
    dut_b (.wb_clk_i(clk), .wb_rst_i(rst), .bus(ifb.slave));

  logic [DW-1:0] dd0 [2], dd1 [2];
  logic          dv0 [2], dv1 [2], dcol [2], dbusy [2];
  assign dd0[0] = ifa.dout0;  assign dv0[0] = ifa.dout0_valid;
  assign dd1[0] = ifa.dout1;  assign dv1[0] = ifa.dout1_valid;
  assign dcol[0] = ifa.collision; assign dbusy[0] = ifa.busy;
  assign dd0[1] = ifb.dout0;  assign dv0[1] = ifb.dout0_valid;
  assign dd1[1] = ifb.dout1;  assign dv1[1] = ifb.dout1_valid;
  assign dcol[1] = ifb.collision; assign dbusy[1] = ifb.busy;

  int npass = 0, ntot = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  function automatic bit wfirst_of(input int k);
    return k == 1;
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [NW-1:0] m);
    logic [DW-1:0] bm;
    bm = '0;
    for (int i = 0; i < NW; i++) bm[i*WW +: WW] = {WW{m[i]}};
    return (old & ~bm) | (nw & bm);
  endfunction

  // ------------------------------------------------------------- model
  logic [DW-1:0] mem_m [DEPTH];
  bit            clearing = 1'b1;
  int            clr_ptr = 0;
  longint        edge_n = 0;
  logic [DW:0]   res0 [longint];   // key = due_edge*2 + dut, {col, data}
  logic [DW:0]   res1 [longint];
  logic [DW-1:0] exp_d0 [2] = '{default: '0};
  logic [DW-1:0] exp_d1 [2] = '{default: '0};
  bit            exp_v0 [2], exp_v1 [2], exp_col [2];
  bit            exp_busy = 1'b1;

  always @(posedge clk or posedge rst) begin : model
    bit            m_wr, m_col;
    logic [DW-1:0] o0, o1, mg;
    if (rst) begin
      clearing = 1'b1;
      clr_ptr  = 0;
      res0.delete();
      res1.delete();
      for (int k = 0; k < 2; k++) begin
        exp_d0[k] = '0; exp_d1[k] = '0;
        exp_v0[k] = 0;  exp_v1[k] = 0; exp_col[k] = 0;
      end
    end else begin
      edge_n++;
      if (clearing) begin
        mem_m[clr_ptr] = '0;
        clr_ptr++;
        if (clr_ptr == DEPTH) begin clearing = 1'b0; clr_ptr = 0; end
      end else begin
        m_wr  = !csb0 && !web0 && (wmask0 != '0);
        o0    = mem_m[addr0];
        o1    = mem_m[addr1];
        mg    = merge(o0, din0, wmask0);
        m_col = m_wr && !csb1 && (addr0 == addr1);
        for (int k = 0; k < 2; k++) begin
          if (!csb0 && web0)
            res0[(edge_n + lat_of(k) - 1) * 2 + k] = {1'b0, o0};
          if (!csb1)
            res1[(edge_n + lat_of(k) - 1) * 2 + k] = {m_col, (m_col && wfirst_of(k)) ? mg : o1};
        end
        if (m_wr) mem_m[addr0] = mg;
        if (clr_req) clearing = 1'b1;
      end
      for (int k = 0; k < 2; k++) begin
        if (res0.exists(edge_n * 2 + k)) begin
          exp_v0[k] = 1; exp_d0[k] = res0[edge_n * 2 + k][DW-1:0];
          res0.delete(edge_n * 2 + k);
        end else exp_v0[k] = 0;
        if (res1.exists(edge_n * 2 + k)) begin
          exp_v1[k] = 1; exp_d1[k] = res1[edge_n * 2 + k][DW-1:0];
          exp_col[k] = res1[edge_n * 2 + k][DW];
          res1.delete(edge_n * 2 + k);
        end else begin
          exp_v1[k] = 0; exp_col[k] = 0;
        end
      end
    end
    exp_busy = clearing;
  end

  // ----------------------------------------------------------- compare
  int            busy_run = 0, busy_last = 0;
  int            v1_streak [2] = '{0, 0};
  int            v1_best [2] = '{0, 0};
  logic [DW-1:0] last_d0 [2], last_d1 [2];
  logic          last_c1 [2];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("busy[%0d]", k), dbusy[k], exp_busy);
      chk($sformatf("dout0_valid[%0d]", k), dv0[k], exp_v0[k]);
      chk($sformatf("dout1_valid[%0d]", k), dv1[k], exp_v1[k]);
      chk($sformatf("collision[%0d]", k), dcol[k], exp_col[k]);
      chk($sformatf("dout0[%0d]", k), dd0[k], exp_d0[k]);
      chk($sformatf("dout1[%0d]", k), dd1[k], exp_d1[k]);
      if (dv0[k]) last_d0[k] = dd0[k];
      if (dv1[k]) begin last_d1[k] = dd1[k]; last_c1[k] = dcol[k]; end
      if (dv1[k]) begin
        v1_streak[k]++;
        if (v1_streak[k] > v1_best[k]) v1_best[k] = v1_streak[k];
      end else v1_streak[k] = 0;
    end
    if (rst) busy_run = 0;
    else if (dbusy[0]) busy_run++;
    else if (busy_run != 0) begin busy_last = busy_run; busy_run = 0; end
  end

  // ---------------------------------------------------------- stimulus
  task automatic idle_inputs();
    csb0 = 1; web0 = 1; wmask0 = '0; addr0 = '0; din0 = '0;
    csb1 = 1; addr1 = '0; clr_req = 0;
  endtask

  task automatic step(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic forget();
    for (int k = 0; k < 2; k++) begin last_d0[k] = 'x; last_d1[k] = 'x; last_c1[k] = 1'bx; end
  endtask

  task automatic p0_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NW-1:0] m);
    csb0 = 0; web0 = 0; addr0 = a; din0 = d; wmask0 = m;
    step(1); idle_inputs();
  endtask

  task automatic p0_read(input logic [AW-1:0] a);
    csb0 = 0; web0 = 1; addr0 = a;
    step(1); idle_inputs();
  endtask

  task automatic p1_read(input logic [AW-1:0] a);
    csb1 = 0; addr1 = a;
    step(1); idle_inputs();
  endtask

  task automatic wait_clear_done(input string nm);
    for (int i = 0; i < 400 && dbusy[0]; i++) step(1);
    chk({nm, "_done"}, dbusy[0], 1'b0);
    chk({nm, "_len"}, busy_last, 256);
  endtask

  initial begin
    idle_inputs();
    forget();
    // Reset with clear-on-reset: full 256-cycle sweep.
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    busy_last = 0;
    wait_clear_done("clr_reset");

    forget();
    p1_read(8'hFF);
    step(2);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rd_ff_d1[%0d]", k), last_d1[k], 32'h0);
      chk($sformatf("rd_ff_col[%0d]", k), last_c1[k], 1'b0);
    end

    // Masked writes merge lanes.
    p0_write(8'h10, 32'hDEADBEEF, 4'b1111);
    p0_write(8'h10, 32'h11223344, 4'b0101);
    forget();
    p0_read(8'h10);
    step(2);
    chk("rd10_a", last_d0[0], 32'hDE22BE44);
    chk("rd10_b", last_d0[1], 32'hDE22BE44);
    chk("model_rd10", exp_d0[1], 32'hDE22BE44);

    // Collision: read-first on A, write-first on B.
    p0_write(8'h20, 32'h12345678, 4'b1111);
    forget();
    csb0 = 0; web0 = 0; addr0 = 8'h20; din0 = 32'hAAAAAAAA; wmask0 = 4'b0011;
    csb1 = 0; addr1 = 8'h20;
    step(1); idle_inputs(); step(2);
    chk("rdw_a_data", last_d1[0], 32'h12345678);
    chk("rdw_b_data", last_d1[1], 32'h1234AAAA);
    chk("rdw_a_col", last_c1[0], 1'b1);
    chk("rdw_b_col", last_c1[1], 1'b1);
    chk("model_rdw_b", exp_d1[1], 32'h1234AAAA);

    // Same address, no lanes enabled: not a collision, no write.
    forget();
    csb0 = 0; web0 = 0; addr0 = 8'h20; din0 = 32'h0; wmask0 = 4'b0000;
    csb1 = 0; addr1 = 8'h20;
    step(1); idle_inputs(); step(2);
    chk("nomask_col_a", last_c1[0], 1'b0);
    chk("nomask_d1_b", last_d1[1], 32'h1234AAAA);

    // Both ports read the same address.
    forget();
    csb0 = 0; web0 = 1; addr0 = 8'h10; csb1 = 0; addr1 = 8'h10;
    step(1); idle_inputs(); step(2);
    chk("dual_rd_d1", last_d1[1], 32'hDE22BE44);
    chk("dual_rd_col", last_c1[1], 1'b0);

    // Back-to-back port-1 reads stream one result per cycle.
    for (int i = 0; i < 8; i++) p0_write(AW'(i), 32'h01010101 * (i + 1), 4'b1111);
    v1_best[0] = 0; v1_best[1] = 0;
    for (int i = 0; i < 8; i++) begin csb1 = 0; addr1 = AW'(i); step(1); end
    idle_inputs(); step(3);
    chk("stream_b_len", v1_best[1], 8);
    chk("stream_a_len", v1_best[0], 8);
    chk("stream_b_last", dd1[1], 32'h08080808);

    // Requested clear; a write and reads issued while busy are dropped.
    clr_req = 1; step(1); clr_req = 0;
    step(9);
    csb0 = 0; web0 = 0; addr0 = 8'h02; din0 = 32'h55555555; wmask0 = 4'b1111;
    csb1 = 0; addr1 = 8'h03;
    step(1); idle_inputs();
    clr_req = 1; step(1); clr_req = 0;
    busy_last = 0;
    wait_clear_done("clr_req");
    for (int a = 0; a < DEPTH; a++) begin
      csb0 = 0; web0 = 1; addr0 = AW'(a); csb1 = 0; addr1 = AW'(DEPTH - 1 - a);
      step(1);
    end
    idle_inputs();
    forget();
    p0_read(8'h02);
    step(2);
    chk("dropped_wr", last_d0[1], 32'h0);

    // Randomised traffic over a small address window to provoke collisions.
    for (int i = 0; i < 1500; i++) begin
      csb0    = ($urandom_range(0, 3) == 0);
      web0    = $urandom_range(0, 1);
      wmask0  = NW'($urandom_range(0, 15));
      addr0   = AW'($urandom_range(0, 15));
      din0    = $urandom;
      csb1    = $urandom_range(0, 1);
      addr1   = AW'($urandom_range(0, 15));
      clr_req = ($urandom_range(0, 399) == 0);
      step(1);
    end
    idle_inputs();
    for (int i = 0; i < 300 && dbusy[0]; i++) step(1);

    // Reset during a clear aborts it and restarts from address 0.
    p0_write(8'h30, 32'hCAFEF00D, 4'b1111);
    csb0 = 0; web0 = 1; addr0 = 8'h30; csb1 = 0; addr1 = 8'h30;
    step(1); idle_inputs(); step(2);
    chk("pre_rst_d0", dd0[1], 32'hCAFEF00D);
    clr_req = 1; step(1); clr_req = 0;
    step(99);
    rst = 1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_dout0[%0d]", k), dd0[k], 32'h0);
      chk($sformatf("rst_dout1[%0d]", k), dd1[k], 32'h0);
    end
    repeat (2) @(posedge clk);
    #1 rst = 0;
    busy_last = 0;
    wait_clear_done("clr_rerun");
    forget();
    p0_read(8'h30);
    step(2);
    chk("post_rst_30", last_d0[0], 32'h0);

    step(2);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
